// File: rtl/uart_pkg.sv
// Shared UART types, constants and the parity helper.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } parity_t;

  typedef enum logic {
    STOP_1 = 1'b0,
    STOP_2 = 1'b1
  } stop_t;

  // XOR of the first 5+bits_code data bits, inverted for odd parity.
  function automatic logic calc_parity(input logic [7:0] data,
                                       input logic [1:0] bits_code,
                                       input parity_t    mode);
    logic p;
    p = (mode == PAR_ODD);
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < (32'd5 + 32'(bits_code))) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fallthrough synchronous FIFO with occupancy output.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage write; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_ctrl.sv
// UART controller: baud tick generator, TX/RX framers, TX and RX FIFOs.
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic [1:0]                    cfg_data_bits,
  input  logic                          cfg_parity_en,
  input  logic                          cfg_parity_odd,
  input  logic                          cfg_stop2,
  input  logic                          cfg_loopback,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  input  logic                          rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_err_parity,
  output logic                          rx_err_frame,
  output logic                          rx_overrun,
  input  logic                          rx_overrun_clr,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level
);

  localparam logic [3:0] BIT_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] BIT_MID  = 4'(OVERSAMPLE / 2 - 1);

  // ---------------- oversample tick ----------------
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [DIV_WIDTH-1:0] div_last;
  logic                 tick;

  assign div_last = (baud_div == '0) ? '0 : baud_div - DIV_WIDTH'(1);
  assign tick     = (div_cnt >= div_last);

  // Free-running divider; >= guards against baud_div shrinking mid-count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_WIDTH'(1);
  end

  // ---------------- TX path ----------------
  logic [7:0]  txf_data;
  logic        txf_full, txf_empty;
  logic        tx_start;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (tx_start),
    .pop_data  (txf_data),
    .full      (txf_full),
    .empty     (txf_empty),
    .level     (tx_level)
  );

  uart_state_t tx_state, tx_state_n;
  logic [3:0]  tx_tcnt, tx_tcnt_n;
  logic [2:0]  tx_bidx, tx_bidx_n;
  logic [7:0]  tx_sh, tx_sh_n;
  logic [1:0]  tx_bits, tx_bits_n;
  logic        tx_par_en, tx_par_en_n;
  stop_t       tx_stop_mode, tx_stop_mode_n;
  logic        tx_par_bit, tx_par_bit_n;
  logic        tx_stop_cnt, tx_stop_cnt_n;
  logic        tx_q, tx_q_n;

  // TX state and line register; reset forces the line idle immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state     <= ST_IDLE;
      tx_tcnt      <= '0;
      tx_bidx      <= '0;
      tx_sh        <= '0;
      tx_bits      <= '0;
      tx_par_en    <= 1'b0;
      tx_stop_mode <= STOP_1;
      tx_par_bit   <= 1'b0;
      tx_stop_cnt  <= 1'b0;
      tx_q         <= 1'b1;
    end else begin
      tx_state     <= tx_state_n;
      tx_tcnt      <= tx_tcnt_n;
      tx_bidx      <= tx_bidx_n;
      tx_sh        <= tx_sh_n;
      tx_bits      <= tx_bits_n;
      tx_par_en    <= tx_par_en_n;
      tx_stop_mode <= tx_stop_mode_n;
      tx_par_bit   <= tx_par_bit_n;
      tx_stop_cnt  <= tx_stop_cnt_n;
      tx_q         <= tx_q_n;
    end
  end

  // TX next state; the last stop bit chains straight into the next start bit.
  always_comb begin
    tx_state_n     = tx_state;
    tx_tcnt_n      = tx_tcnt;
    tx_bidx_n      = tx_bidx;
    tx_sh_n        = tx_sh;
    tx_bits_n      = tx_bits;
    tx_par_en_n    = tx_par_en;
    tx_stop_mode_n = tx_stop_mode;
    tx_par_bit_n   = tx_par_bit;
    tx_stop_cnt_n  = tx_stop_cnt;
    tx_q_n         = tx_q;
    tx_start       = 1'b0;

    case (tx_state)
      ST_IDLE: begin
        if (tick && !txf_empty) tx_start = 1'b1;
      end
      ST_START: begin
        if (tick) begin
          if (tx_tcnt == BIT_LAST) begin
            tx_tcnt_n  = '0;
            tx_bidx_n  = '0;
            tx_state_n = ST_DATA;
            tx_q_n     = tx_sh[0];
          end else begin
            tx_tcnt_n = tx_tcnt + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (tx_tcnt == BIT_LAST) begin
            tx_tcnt_n = '0;
            if (tx_bidx == {1'b1, tx_bits}) begin
              if (tx_par_en) begin
                tx_state_n = ST_PARITY;
                tx_q_n     = tx_par_bit;
              end else begin
                tx_state_n    = ST_STOP;
                tx_q_n        = 1'b1;
                tx_stop_cnt_n = 1'b0;
              end
            end else begin
              tx_bidx_n = tx_bidx + 3'd1;
              tx_sh_n   = {1'b0, tx_sh[7:1]};
              tx_q_n    = tx_sh[1];
            end
          end else begin
            tx_tcnt_n = tx_tcnt + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          if (tx_tcnt == BIT_LAST) begin
            tx_tcnt_n     = '0;
            tx_state_n    = ST_STOP;
            tx_q_n        = 1'b1;
            tx_stop_cnt_n = 1'b0;
          end else begin
            tx_tcnt_n = tx_tcnt + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (tx_tcnt == BIT_LAST) begin
            tx_tcnt_n = '0;
            if (tx_stop_mode == STOP_2 && !tx_stop_cnt) begin
              tx_stop_cnt_n = 1'b1;
            end else if (!txf_empty) begin
              tx_start = 1'b1;
            end else begin
              tx_state_n = ST_IDLE;
            end
          end else begin
            tx_tcnt_n = tx_tcnt + 4'd1;
          end
        end
      end
      default: tx_state_n = ST_IDLE;
    endcase

    // Frame start: pop the head and latch the config for the whole frame.
    if (tx_start) begin
      tx_state_n     = ST_START;
      tx_tcnt_n      = '0;
      tx_q_n         = 1'b0;
      tx_sh_n        = txf_data;
      tx_bits_n      = cfg_data_bits;
      tx_par_en_n    = cfg_parity_en;
      tx_stop_mode_n = stop_t'(cfg_stop2);
      tx_par_bit_n   = calc_parity(txf_data, cfg_data_bits, parity_t'(cfg_parity_odd));
    end
  end

  assign tx       = tx_q;
  assign tx_busy  = (tx_state != ST_IDLE);
  assign tx_ready = !txf_full;

  // ---------------- RX path ----------------
  logic rx_s1, rx_s2, rx_in;

  // Two-flop synchroniser on the asynchronous rx pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  assign rx_in = cfg_loopback ? tx_q : rx_s2;

  uart_state_t rx_state, rx_state_n;
  logic [3:0]  rx_tcnt, rx_tcnt_n;
  logic [2:0]  rx_bidx, rx_bidx_n;
  logic [7:0]  rx_sh, rx_sh_n;
  logic [1:0]  rx_bits, rx_bits_n;
  logic        rx_par_en, rx_par_en_n;
  parity_t     rx_par_mode, rx_par_mode_n;
  logic        rx_perr, rx_perr_n;
  logic        rx_push;
  logic [9:0]  rx_entry;
  logic [9:0]  rxf_data;
  logic        rxf_full, rxf_empty;

  // RX state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state    <= ST_IDLE;
      rx_tcnt     <= '0;
      rx_bidx     <= '0;
      rx_sh       <= '0;
      rx_bits     <= '0;
      rx_par_en   <= 1'b0;
      rx_par_mode <= PAR_EVEN;
      rx_perr     <= 1'b0;
    end else begin
      rx_state    <= rx_state_n;
      rx_tcnt     <= rx_tcnt_n;
      rx_bidx     <= rx_bidx_n;
      rx_sh       <= rx_sh_n;
      rx_bits     <= rx_bits_n;
      rx_par_en   <= rx_par_en_n;
      rx_par_mode <= rx_par_mode_n;
      rx_perr     <= rx_perr_n;
    end
  end

  // RX next state: validate start at mid-bit, then sample every 16 ticks.
  always_comb begin
    rx_state_n    = rx_state;
    rx_tcnt_n     = rx_tcnt;
    rx_bidx_n     = rx_bidx;
    rx_sh_n       = rx_sh;
    rx_bits_n     = rx_bits;
    rx_par_en_n   = rx_par_en;
    rx_par_mode_n = rx_par_mode;
    rx_perr_n     = rx_perr;
    rx_push       = 1'b0;
    rx_entry      = {rx_perr, ~rx_in, rx_sh};

    case (rx_state)
      ST_IDLE: begin
        if (tick && !rx_in) begin
          rx_state_n    = ST_START;
          rx_tcnt_n     = '0;
          rx_sh_n       = '0;
          rx_perr_n     = 1'b0;
          rx_bits_n     = cfg_data_bits;
          rx_par_en_n   = cfg_parity_en;
          rx_par_mode_n = parity_t'(cfg_parity_odd);
        end
      end
      ST_START: begin
        if (tick) begin
          if (rx_tcnt == BIT_MID) begin
            rx_tcnt_n = '0;
            rx_bidx_n = '0;
            rx_state_n = rx_in ? ST_IDLE : ST_DATA;
          end else begin
            rx_tcnt_n = rx_tcnt + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (rx_tcnt == BIT_LAST) begin
            rx_tcnt_n          = '0;
            rx_sh_n[rx_bidx]   = rx_in;
            if (rx_bidx == {1'b1, rx_bits}) begin
              rx_state_n = rx_par_en ? ST_PARITY : ST_STOP;
            end else begin
              rx_bidx_n = rx_bidx + 3'd1;
            end
          end else begin
            rx_tcnt_n = rx_tcnt + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          if (rx_tcnt == BIT_LAST) begin
            rx_tcnt_n  = '0;
            rx_perr_n  = (rx_in != calc_parity(rx_sh, rx_bits, rx_par_mode));
            rx_state_n = ST_STOP;
          end else begin
            rx_tcnt_n = rx_tcnt + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (rx_tcnt == BIT_LAST) begin
            rx_tcnt_n  = '0;
            rx_push    = 1'b1;
            rx_state_n = ST_IDLE;
          end else begin
            rx_tcnt_n = rx_tcnt + 4'd1;
          end
        end
      end
      default: rx_state_n = ST_IDLE;
    endcase
  end

  sync_fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_entry),
    .pop       (rx_ready),
    .pop_data  (rxf_data),
    .full      (rxf_full),
    .empty     (rxf_empty),
    .level     (rx_level)
  );

  // Sticky overrun; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     rx_overrun <= 1'b0;
    else if (rx_push && rxf_full)  rx_overrun <= 1'b1;
    else if (rx_overrun_clr)       rx_overrun <= 1'b0;
  end

  assign rx_valid      = !rxf_empty;
  assign rx_data       = rx_valid ? rxf_data[7:0] : '0;
  assign rx_err_frame  = rx_valid & rxf_data[8];
  assign rx_err_parity = rx_valid & rxf_data[9];

endmodule
